// File: rtl/duty_ramp.sv
// Duty-cycle ramp generator: walks the PWM compare word one LSB per STEP_DIV
// PWM periods toward an accepted target. Define DUTY_RAMP_RETARGET_EN to allow retargeting mid-ramp.
module duty_ramp #(
  parameter int CTR_LEN  = 6,
  parameter int STEP_DIV = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               period_start,
  input  logic [CTR_LEN-1:0] target,
  input  logic               target_valid,
  output logic               target_ready,
  output logic [CTR_LEN-1:0] compare,
  output logic               busy,
  output logic               done
);

  localparam int DIV_W = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t             state_q, state_d;
  logic [CTR_LEN-1:0] tgt_q, tgt_d, cmp_d, eff_tgt;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               done_q, done_d;
  logic               accept;

`ifdef DUTY_RAMP_RETARGET_EN
  assign target_ready = !reset;
  assign eff_tgt      = accept ? target : tgt_q;
`else
  assign target_ready = !reset && (state_q == IDLE);
  assign eff_tgt      = tgt_q;
`endif

  assign accept  = target_valid && target_ready;
  assign busy    = (state_q == RAMP);
  assign done    = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      div_q   <= '0;
      compare <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      div_q   <= div_d;
      compare <= cmp_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    div_d   = div_q;
    cmp_d   = compare;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d = target;
          if (target == compare) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
            div_d   = '0;
          end
        end
      end
      RAMP: begin
        if (accept) tgt_d = target;
        // tgt_q never equals compare while ramping, so this only fires on a retarget
        if (eff_tgt == compare) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (period_start) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            cmp_d = (eff_tgt > compare) ? compare + 1'b1 : compare - 1'b1;
            if (cmp_d == eff_tgt) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_duty_ramp.sv
// Scoreboard bench for duty_ramp: u4 runs STEP_DIV=4, u1 runs STEP_DIV=1; a
// monitor pops one expected record per compare change or done pulse.
module tb_duty_ramp;

`ifdef DUTY_RAMP_RETARGET_EN
  localparam int RETGT = 1;
`else
  localparam int RETGT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst [2];
  logic       ps  [2];
  logic       tv  [2];
  logic [5:0] tg  [2];
  logic       rdy [2];
  logic [5:0] cmp [2];
  logic       bsy [2];
  logic       dn  [2];

  always #5 clk = ~clk;

  duty_ramp #(.CTR_LEN(6), .STEP_DIV(4)) u4 (
    .clk(clk), .reset(rst[0]), .period_start(ps[0]), .target(tg[0]),
    .target_valid(tv[0]), .target_ready(rdy[0]), .compare(cmp[0]),
    .busy(bsy[0]), .done(dn[0]));

  duty_ramp #(.CTR_LEN(6), .STEP_DIV(1)) u1 (
    .clk(clk), .reset(rst[1]), .period_start(ps[1]), .target(tg[1]),
    .target_valid(tv[1]), .target_ready(rdy[1]), .compare(cmp[1]),
    .busy(bsy[1]), .done(dn[1]));

  typedef struct {int id; int cmp; int done; int busy;} exp_t;
  exp_t sbq[$];

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   track  = 1'b1;
  logic [5:0] prev [2] = '{6'd0, 6'd0};
  logic ps_seen [2] = '{1'b0, 1'b0};
  logic rst_seen[2] = '{1'b1, 1'b1};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input int c, input int d, input int b);
    exp_t e;
    e.id = id; e.cmp = c; e.done = d; e.busy = b;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int i);
    ps[i] = 1'b1;
    tick();
    ps[i] = 1'b0;
    tick();
  endtask

  task automatic accept(input int i, input logic [5:0] t);
    tv[i] = 1'b1;
    tg[i] = t;
    tick();
    tv[i] = 1'b0;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ps_seen[i]  <= ps[i];
      rst_seen[i] <= rst[i];
    end
  end

  // Every compare change must land on a period_start edge (or reset)
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (cmp[i] != prev[i] || dn[i]) begin
          if (cmp[i] != prev[i] && !rst_seen[i])
            chk($sformatf("glitch_u%0d", i), int'(ps_seen[i]), 1);
          if (track) begin
            if (sbq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_event u%0d got cmp=%0d done=%0d want none t=%0t",
                       i, cmp[i], dn[i], $time);
            end else begin
              e = sbq.pop_front();
              chk("sb_id",   i,            e.id);
              chk("sb_cmp",  int'(cmp[i]), e.cmp);
              chk("sb_done", int'(dn[i]),  e.done);
              chk("sb_busy", int'(bsy[i]), e.busy);
            end
          end
        end
        prev[i] = cmp[i];
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; ps[i] = 1'b0; tv[i] = 1'b0; tg[i] = '0;
    end
    repeat (2) tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cmp",   int'(cmp[i]), 0);
      chk("rst_busy",  int'(bsy[i]), 0);
      chk("rst_done",  int'(dn[i]),  0);
      chk("rst_ready", int'(rdy[i]), 0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("post_rst_ready0", int'(rdy[0]), 1);
    chk("post_rst_ready1", int'(rdy[1]), 1);
    mon_en = 1'b1;

    // Ramp up 0->3, STEP_DIV=4
    push(0, 1, 0, 1); push(0, 2, 0, 1); push(0, 3, 1, 0);
    accept(0, 6'd3);
    @(negedge clk);
    chk("up_busy", int'(bsy[0]), 1);
    chk("up_ready_ramp", int'(rdy[0]), RETGT);
    repeat (12) pulse(0);
    chk("up_busy_end", int'(bsy[0]), 0);

    // Ramp 3->20, then equal-target request
    for (int v = 4; v <= 20; v++) push(0, v, int'(v == 20), int'(v != 20));
    accept(0, 6'd20);
    repeat (68) pulse(0);
    push(0, 20, 1, 0);
    accept(0, 6'd20);
    @(negedge clk);
    chk("eq_cmp",  int'(cmp[0]), 20);
    chk("eq_busy", int'(bsy[0]), 0);
    tick();
    @(negedge clk);
    chk("eq_done_once", int'(dn[0]), 0);

    // Reset mid-ramp 0->40 at compare=17
    push(0, 0, 0, 0);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    for (int v = 1; v <= 17; v++) push(0, v, 0, 1);
    accept(0, 6'd40);
    repeat (68) pulse(0);
    push(0, 0, 0, 0);
    rst[0] = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_ready_in_rst", int'(rdy[0]), 0);
    rst[0] = 1'b0;
    @(negedge clk);
    chk("midrst_cmp",   int'(cmp[0]), 0);
    chk("midrst_busy",  int'(bsy[0]), 0);
    chk("midrst_done",  int'(dn[0]),  0);
    chk("midrst_ready", int'(rdy[0]), 1);

    // STEP_DIV=1: up to 63, down to 0, then saturate
    for (int v = 1; v <= 63; v++) push(1, v, int'(v == 63), int'(v != 63));
    accept(1, 6'd63);
    repeat (63) pulse(1);
    for (int v = 62; v >= 0; v--) push(1, v, int'(v == 0), int'(v != 0));
    accept(1, 6'd0);
    repeat (63) pulse(1);
    repeat (5) pulse(1);
    @(negedge clk);
    chk("sat_cmp",  int'(cmp[1]), 0);
    chk("sat_busy", int'(bsy[1]), 0);

    // Handshake: ramp 30->10 with target=50 held valid throughout
    for (int v = 1; v <= 30; v++) push(1, v, int'(v == 30), int'(v != 30));
    accept(1, 6'd30);
    repeat (30) pulse(1);
`ifdef DUTY_RAMP_RETARGET_EN
    for (int v = 31; v <= 50; v++) push(1, v, int'(v == 50), int'(v != 50));
`else
    for (int v = 29; v >= 10; v--) push(1, v, int'(v == 10), int'(v != 10));
    for (int v = 11; v <= 50; v++) push(1, v, int'(v == 50), int'(v != 50));
`endif
    tv[1] = 1'b1;
    tg[1] = 6'd10;
    tick();
    tg[1] = 6'd50;
    tick();
    @(negedge clk);
    chk("hs_ready_ramp", int'(rdy[1]), RETGT);
    chk("hs_busy", int'(bsy[1]), 1);
    repeat ((RETGT != 0 ? 20 : 60) - 1) pulse(1);
    ps[1] = 1'b1;
    tick();
    ps[1] = 1'b0;
    tv[1] = 1'b0;
    tick();
    @(negedge clk);
    chk("hs_final_cmp", int'(cmp[1]), 50);
    chk("sb_drained", sbq.size(), 0);

    // Random request traffic, period_start every 64 cycles
    track = 1'b0;
    for (int k = 0; k < 40; k++) begin
      repeat (63) begin
        tv[0] = ($urandom_range(0, 3) == 0);
        tg[0] = 6'($urandom_range(0, 63));
        tick();
      end
      ps[0] = 1'b1;
      tick();
      ps[0] = 1'b0;
    end
    tv[0] = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/duty_ramp.md
DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 The module SHALL have parameter CTR_LEN, default 6, giving the duty word width, matching the downstream PWM compare width.
REQ-002 The module SHALL have parameter STEP_DIV, default 16, giving the number of PWM periods per one-LSB duty step; legal range 1..255.
REQ-003 The module SHALL have port clk, input, 1 bit, the clock.
REQ-004 The module SHALL have port reset, input, 1 bit, the synchronous active-high reset.
REQ-005 The module SHALL have port period_start, input, 1 bit, a one-cycle pulse asserted when the downstream PWM counter wraps to 0.
REQ-006 The module SHALL have port target, input, CTR_LEN bits, the requested final duty value.
REQ-007 The module SHALL have port target_valid, input, 1 bit, which qualifies target.
REQ-008 The module SHALL have port target_ready, output, 1 bit; target is accepted on a cycle where target_valid and target_ready are both 1.
REQ-009 The module SHALL have port compare, output, CTR_LEN bits, a registered duty value driven to the PWM compare input.
REQ-010 The module SHALL have port busy, output, 1 bit, asserted while a ramp is in progress.
REQ-011 The module SHALL have port done, output, 1 bit, a one-cycle pulse when compare reaches the accepted target.

Function
REQ-012 The module SHALL implement the states IDLE and RAMP, and SHALL drive busy=1 only in RAMP.
REQ-013 In IDLE the module SHALL drive target_ready=1.
REQ-014 On acceptance in IDLE, the module SHALL latch target into tgt_q.
REQ-015 If the accepted target equals compare, the module SHALL pulse done on the next cycle and remain in IDLE.
REQ-016 If the accepted target differs from compare, the module SHALL enter RAMP on the next cycle and clear the divider count div_q to 0.
REQ-017 In RAMP, div_q SHALL increment on each period_start pulse, counting 0..STEP_DIV-1.
REQ-018 On a period_start with div_q==STEP_DIV-1, the module SHALL set div_q to 0 and move compare by exactly 1 toward tgt_q (increment if tgt_q>compare, decrement otherwise) in the same clock edge.
REQ-019 compare SHALL change only on a period_start cycle, so the PWM never sees a mid-period duty change.
REQ-020 When the step of REQ-018 makes compare equal tgt_q, the module SHALL return to IDLE and pulse done for exactly one cycle, aligned with the first cycle compare holds the final value.
REQ-021 A full ramp SHALL take |tgt_q - compare_start| * STEP_DIV period_start pulses.
REQ-022 compare SHALL never wrap: it moves only toward tgt_q, so it stays within 0..2^CTR_LEN-1.
REQ-023 period_start pulses in IDLE SHALL have no effect.
REQ-024 target_valid in the same cycle as period_start SHALL follow REQ-014..016 with no extra step.
REQ-025 With STEP_DIV=1, the module SHALL step compare on every period_start pulse.

Reset
REQ-026 While reset=1, the module SHALL set compare=0, tgt_q=0, div_q=0, state=IDLE, busy=0 and done=0.
REQ-027 While reset=1, the module SHALL drive target_ready=0; target_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-028 Reset asserted mid-ramp SHALL abort the ramp immediately with no done pulse, and compare SHALL be 0 on the next cycle.

Configuration
REQ-029 With macro DUTY_RAMP_RETARGET_EN defined, the module SHALL hold target_ready=1 in RAMP as well as in IDLE.
REQ-030 With DUTY_RAMP_RETARGET_EN defined, acceptance in RAMP SHALL overwrite tgt_q without clearing div_q and without a done pulse.
REQ-031 With DUTY_RAMP_RETARGET_EN defined, if the new tgt_q equals the current compare, the module SHALL return to IDLE and pulse done on the next cycle; otherwise ramping SHALL continue toward the new tgt_q, reversing direction if needed.
REQ-032 Without DUTY_RAMP_RETARGET_EN, the module SHALL drive target_ready=0 in RAMP and SHALL ignore target_valid there.

Verification
REQ-033 Ramp up: the bench SHALL apply STEP_DIV=4, compare=0 and accept target=3, and SHALL check that compare reaches 1, 2, 3 after the 4th, 8th and 12th period_start, done pulses once at the 12th, and busy falls together with done.
REQ-034 Ramp down and saturation: the bench SHALL apply STEP_DIV=1, compare=63 and target=0, and SHALL check 63 decrements to 0 over 63 pulses, no wrap, done once, and further pulses leave compare at 0.
REQ-035 Equal target: the bench SHALL apply target=compare=20, and SHALL check done pulses on the next cycle, busy stays 0, and compare is unchanged.
REQ-036 Reset mid-ramp: the bench SHALL assert reset during a 0->40 ramp at compare=17, and SHALL check compare=0, busy=0, no done pulse, and target_ready=1 on the first cycle after release.
REQ-037 Handshake: the bench SHALL hold target_valid=1 with target=50 throughout a ramp to 10, and SHALL check it is not accepted until IDLE without the macro, and is accepted immediately with reversal toward 50 with DUTY_RAMP_RETARGET_EN.
REQ-038 Glitch-free update: the bench SHALL drive random target_valid traffic and period_start every 64 cycles, and SHALL check that compare changes only in period_start cycles.
